// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, RV32I opcodes and issue kinds
package alu_pkg;

  localparam int XLEN_MAX = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] KIND_ALU    = 3'd0;
  localparam logic [2:0] KIND_LOAD   = 3'd1;
  localparam logic [2:0] KIND_STORE  = 3'd2;
  localparam logic [2:0] KIND_BRANCH = 3'd3;
  localparam logic [2:0] KIND_UPPER  = 3'd4;

  typedef struct packed {
    logic [3:0]          op;
    logic [XLEN_MAX-1:0] a;
    logic [XLEN_MAX-1:0] b;
    logic [4:0]          rd;
    logic [2:0]          kind;
    logic [2:0]          funct3;
    logic                illegal;
  } issue_t;

  // alt selects SUB/SRA; only meaningful for funct3 000 and 101
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - upstream instruction and downstream ALU operand handshake bundle
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_op;
  logic [4:0]      out_rd;
  logic [2:0]      out_kind;
  logic [2:0]      out_funct3;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_kind, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_kind, out_funct3, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational RV32I decode into ALU op, operands, rd and kind
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      rd,
  output logic [2:0]      kind,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};
  // register operands arrive already read, so the rs1 index field is not needed
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    op      = OP_ADD;
    a       = rs1;
    b       = '0;
    rd      = instr[11:7];
    kind    = KIND_ALU;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        b       = rs2;
        op      = f3_to_op(funct3, funct7[5]);
        illegal = !((funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        b  = imm_i;
        op = f3_to_op(funct3, 1'b0);
        if (funct3 == 3'b001) begin
          b       = shamt;
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          b       = shamt;
          op      = funct7[5] ? OP_SRA : OP_SRL;
          illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
        end
      end
      OPC_LOAD: begin
        b    = imm_i;
        kind = KIND_LOAD;
      end
      OPC_STORE: begin
        b    = imm_s;
        rd   = '0;
        kind = KIND_STORE;
      end
      OPC_BRANCH: begin
        b    = rs2;
        rd   = '0;
        kind = KIND_BRANCH;
        case (funct3)
          3'b000, 3'b001: op = OP_SUB;
          3'b100, 3'b101: op = OP_SLT;
          3'b110, 3'b111: op = OP_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        a    = '0;
        b    = imm_u;
        kind = KIND_UPPER;
      end
      OPC_AUIPC: begin
        a    = pc;
        b    = imm_u;
        kind = KIND_UPPER;
      end
      default: illegal = 1'b1;
    endcase
    // undecodable words collapse to a harmless ADD rs1+0 with no writeback
    if (illegal) begin
      op   = OP_ADD;
      a    = rs1;
      b    = '0;
      rd   = '0;
      kind = KIND_ALU;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue stage: decoder behind a two-entry output/skid buffer
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_ADD = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic [2:0]      dec_kind;
  logic            dec_illegal;
  issue_t          dec_entry;

  issue_t out_q;
  issue_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   accept;

  alu_issue_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .op      (dec_op),
    .a       (dec_a),
    .b       (dec_b),
    .rd      (dec_rd),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_entry         = '0;
    dec_entry.op      = dec_op;
    dec_entry.a       = dec_a;
    dec_entry.b       = dec_b;
    dec_entry.rd      = dec_rd;
    dec_entry.kind    = dec_kind;
    dec_entry.funct3  = bus.in_instr[14:12];
    dec_entry.illegal = dec_illegal;
  end

  // when illegal words are dropped they are still handshaken, just never stored
  assign accept = bus.in_valid && !skid_valid_q && (ILLEGAL_AS_ADD || !dec_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_op      = out_q.op;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_kind    = out_q.kind;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with directed RV32I vectors
module tb_alu_issue;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  issue_t sb[$];

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [2:0] kind,
                                input logic [2:0] f3, input logic ill);
    issue_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.kind = kind; e.funct3 = f3; e.illegal = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: a transfer seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      issue_t act;
      act = mk(bus.out_op, bus.out_a, bus.out_b, bus.out_rd, bus.out_kind,
               bus.out_funct3, bus.out_illegal);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got op=%h a=%h b=%h rd=%0d", act.op, act.a, act.b, act.rd);
      end else begin
        issue_t e;
        e = sb.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL output: got op=%h a=%h b=%h rd=%0d kind=%0d f3=%0d ill=%0b expected op=%h a=%h b=%h rd=%0d kind=%0d f3=%0d ill=%0b",
                   act.op, act.a, act.b, act.rd, act.kind, act.funct3, act.illegal,
                   e.op, e.a, e.b, e.rd, e.kind, e.funct3, e.illegal);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input issue_t e);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL send_timeout: got in_ready=0 expected 1 for instr %h", instr);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_a", bus.out_a, 0);
    chk("reset_out_b", bus.out_b, 0);
    chk("reset_out_op", bus.out_op, 0);
    chk("reset_out_rd", bus.out_rd, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(OP_ADD, 32'd5, 32'd7, 5'd3, KIND_ALU, 3'd0, 1'b0));
    send(32'h402081B3, 32'h0, 32'd5, 32'd7, mk(OP_SUB, 32'd5, 32'd7, 5'd3, KIND_ALU, 3'd0, 1'b0));
    send(32'h40315093, 32'h0, 32'h80000000, 32'd9,
         mk(OP_SRA, 32'h80000000, 32'd3, 5'd1, KIND_ALU, 3'd5, 1'b0));
    send(32'hFFF00093, 32'h0, 32'h0, 32'd9, mk(OP_ADD, 32'h0, 32'hFFFFFFFF, 5'd1, KIND_ALU, 3'd0, 1'b0));
    send(32'h123452B7, 32'h100, 32'h55, 32'd9,
         mk(OP_ADD, 32'h0, 32'h12345000, 5'd5, KIND_UPPER, 3'd5, 1'b0));
    send(32'h12345297, 32'h100, 32'h55, 32'd9,
         mk(OP_ADD, 32'h100, 32'h12345000, 5'd5, KIND_UPPER, 3'd5, 1'b0));
    send(32'h0080A203, 32'h0, 32'h1000, 32'd9, mk(OP_ADD, 32'h1000, 32'd8, 5'd4, KIND_LOAD, 3'd2, 1'b0));
    send(32'hFE20AE23, 32'h0, 32'h2000, 32'd9,
         mk(OP_ADD, 32'h2000, 32'hFFFFFFFC, 5'd0, KIND_STORE, 3'd2, 1'b0));
    send(32'h0020C063, 32'h0, 32'd3, 32'd4, mk(OP_SLT, 32'd3, 32'd4, 5'd0, KIND_BRANCH, 3'd4, 1'b0));
    send(32'h0000007F, 32'h0, 32'hAB, 32'd9, mk(OP_ADD, 32'hAB, 32'h0, 5'd0, KIND_ALU, 3'd0, 1'b1));
    send(32'h022081B3, 32'h0, 32'hCD, 32'd9, mk(OP_ADD, 32'hCD, 32'h0, 5'd0, KIND_ALU, 3'd0, 1'b1));
    send(32'h0020A063, 32'h0, 32'hEF, 32'd9, mk(OP_ADD, 32'hEF, 32'h0, 5'd0, KIND_ALU, 3'd2, 1'b1));
    drain();

    // four back-to-back instructions against a three-cycle stall
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h002081B3, 32'h0, 32'h11, 32'h22, mk(OP_ADD, 32'h11, 32'h22, 5'd3, KIND_ALU, 3'd0, 1'b0));
        send(32'h0020C1B3, 32'h0, 32'h33, 32'h44, mk(OP_XOR, 32'h33, 32'h44, 5'd3, KIND_ALU, 3'd4, 1'b0));
        send(32'h0020E1B3, 32'h0, 32'h55, 32'h66, mk(OP_OR, 32'h55, 32'h66, 5'd3, KIND_ALU, 3'd6, 1'b0));
        send(32'h01F11093, 32'h0, 32'h77, 32'h88, mk(OP_SLL, 32'h77, 32'd31, 5'd1, KIND_ALU, 3'd1, 1'b0));
      end
      begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_out_valid", bus.out_valid, 1);
          chk("stall_out_a", bus.out_a, 32'h11);
          chk("stall_out_b", bus.out_b, 32'h22);
        end
        chk("stall_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // fill both entries, then assert reset between clock edges
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(OP_ADD, 32'd1, 32'd2, 5'd3, KIND_ALU, 3'd0, 1'b0));
    send(32'h002081B3, 32'h0, 32'd3, 32'd4, mk(OP_ADD, 32'd3, 32'd4, 5'd3, KIND_ALU, 3'd0, 1'b0));
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h0020F1B3, 32'h0, 32'hF0, 32'h3C, mk(OP_AND, 32'hF0, 32'h3C, 5'd3, KIND_ALU, 3'd7, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue/decode stage that drives the ALU's operand and operation interface. It accepts an RV32I instruction with its source register values and PC over a valid/ready handshake. It decodes the instruction into the 4-bit ALU op code plus the A and B operands and the destination register. Results are registered behind a skid buffer so the downstream ALU/execute stage can stall without losing or duplicating instructions.

Parameters:
XLEN, 32, datapath width; the only supported value is 32.
ILLEGAL_AS_ADD, 1, when set, illegal instructions issue as an ADD with the illegal flag raised; when clear, they are dropped (accepted but never issued).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  RV32I instruction word
in_pc  in  32  instruction PC
in_rs1  in  32  rs1 register value
in_rs2  in  32  rs2 register value
out_valid  out  1  decoded op valid
out_ready  in  1  ALU/execute stage accepts
out_a  out  32  ALU operand A
out_b  out  32  ALU operand B
out_op  out  4  ALU op code
out_rd  out  5  destination register (0 for branch/store)
out_kind  out  3  0=ALU, 1=LOAD, 2=STORE, 3=BRANCH, 4=LUI/AUIPC
out_funct3  out  3  raw funct3, passed through for branch/memory sizing
out_illegal  out  1  instruction not decodable

Behaviour:
- Reset: out_valid=0, skid buffer empty, in_ready=1. All data outputs reset to 0.
- Op codes: ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SLL 1000, SRL 1010, SRA 1011, SLT 1100, SLTU 1101. No other code is ever emitted.
- OP (0110011):
  - a=rs1, b=rs2.
  - funct3/funct7 map to ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - funct7 must be 0000000, or 0100000 for SUB/SRA only; anything else is illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended I-imm.
  - Shifts use b={27'b0,shamt}. SLLI requires funct7=0; SRLI/SRAI require imm[11:5]=0000000 or 0100000.
  - Otherwise funct3 maps as for OP, with no SUB.
- LOAD (0000011): ADD, a=rs1, b=I-imm.
- STORE (0100011): ADD, a=rs1, b=S-imm, rd=0.
- BRANCH (1100011): a=rs1, b=rs2, rd=0.
  - BEQ/BNE use SUB (execute tests zero).
  - BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - funct3 010/011 is illegal.
- LUI (0110111): ADD, a=0, b={imm[31:12],12'b0}.
- AUIPC (0010111): ADD, a=pc, b={imm[31:12],12'b0}.
- Any other opcode is illegal.
- Illegal instructions: op=ADD, a=rs1, b=0, rd=0, illegal=1 (ILLEGAL_AS_ADD=1).
- Sign extension is always from instruction bit 31.
- Handshake and buffering:
  - A transfer occurs on valid&&ready at the rising edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented on out_* after edge N.
  - Two entries: output register plus skid register. in_ready is registered and equals "skid empty".
  - If the output register is occupied and not consumed, a new acceptance goes to the skid register.
  - When the output is consumed, skid contents move to the output register on the same edge.
  - Accept and consume on the same edge with skid empty: the new entry goes directly to the output register.
  - Full throughput (1/cycle) is sustained while out_ready=1.
- out_* fields are stable while out_valid=1 and out_ready=0 (no change until the transfer).
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.
- Reset asserted mid-stream discards both entries immediately (asynchronous). The first accept after deassertion behaves as after power-on.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op code localparams (shared with the ALU).
  - RV32I opcode constants.
  - out_kind encodings.
- One natural sub-module, alu_issue_decode: purely combinational instruction-to-{op,a,b,rd,kind,illegal} decoder.
- alu_issue wraps the decoder with the skid-buffer handshake.

Test Plan:
1. ADD: in_instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle out_op=0000, a=5, b=7, rd=3, kind=0, illegal=0.
2. SUB and SRAI: 0x402081B3 -> op=0001. Then 0x40315093 (srai x1,x2,3) -> op=1011, b=3, rd=1.
3. Immediates: 0xFFF00093 (addi x1,x0,-1) -> b=0xFFFFFFFF. 0x123452B7 (lui x5,0x12345) with pc=0x100 -> a=0, b=0x12345000, rd=5. Same word as AUIPC (0x12345297) -> a=0x100.
4. Backpressure: stream 4 instructions back-to-back with out_ready=0 for 3 cycles.
   -> in_ready drops after 2 accepts.
   -> out_* held stable.
   -> After release, all 4 emerge in order with no duplicates or drops.
5. Illegal: 0x0000007F and 0x022081B3 (funct7=0000001) -> illegal=1, op=0000, b=0, rd=0.
6. Async reset mid-stall with both entries full -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
